// File: rtl/vec_mem_seq.sv
// Vector memory sequencer: walks a strided load or store over DRAM one element per
// cycle; load data returns RD_LAT cycles later and is written to the register file.
module vec_mem_seq #(
  parameter int VLEN   = 16,
  parameter int RD_LAT = 1
) (
  input  logic                    Clk1,
  input  logic                    Reset,
  input  logic                    Start,
  input  logic                    Op,
  input  logic [15:0]             BaseAddr,
  input  logic [15:0]             Stride,
  input  logic [4:0]              Count,
  input  logic [15:0]             ElemIn,
  output logic [$clog2(VLEN)-1:0] ElemIdx,
  output logic [15:0]             ElemOut,
  output logic                    ElemWE,
  output logic                    Busy,
  output logic                    Done,
  output logic [15:0]             Addr,
  output logic                    RD,
  output logic                    WR,
  output logic [15:0]             DataOut,
  input  logic [15:0]             DataIn
);
  // state | meaning
  // IDLE  | waiting for Start
  // ISSUE | one DRAM access per cycle
  // DRAIN | load fully issued, waiting for the last read to return
  localparam int IDX_W = $clog2(VLEN);
  localparam int TAIL  = RD_LAT - 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                        state_q, state_d;
  logic                          op_q, op_d;
  logic [15:0]                   stride_q, stride_d;
  logic [15:0]                   addr_q, addr_d;
  logic [15:0]                   dout_q, dout_d;
  logic [IDX_W-1:0]              last_q, last_d;
  logic [IDX_W-1:0]              iss_idx_q, iss_idx_d;
  logic                          done_q, done_d;
  logic [RD_LAT-1:0]             vld_q, vld_d;
  logic [RD_LAT-1:0][IDX_W-1:0]  pidx_q, pidx_d;
  logic [4:0]                    cnt_clamp;

  assign cnt_clamp = (Count > 5'(VLEN)) ? 5'(VLEN) : Count;

  assign RD      = (state_q == ISSUE) && !op_q;
  assign WR      = (state_q == ISSUE) && op_q;
  assign Addr    = addr_q;
  assign DataOut = WR ? ElemIn : dout_q;
  assign ElemWE  = vld_q[TAIL];
  assign ElemOut = DataIn;
  assign ElemIdx = WR ? iss_idx_q : pidx_q[TAIL];
  assign Busy    = (state_q != IDLE);
  assign Done    = done_q;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    stride_d  = stride_q;
    addr_d    = addr_q;
    last_d    = last_q;
    iss_idx_d = iss_idx_q;
    done_d    = 1'b0;
    dout_d    = WR ? ElemIn : dout_q;

    // Read-return tracker: one stage per cycle of DRAM read latency.
    vld_d     = vld_q;
    pidx_d    = pidx_q;
    vld_d[0]  = RD;
    pidx_d[0] = iss_idx_q;
    for (int k = 1; k < RD_LAT; k++) begin
      vld_d[k]  = vld_q[k-1];
      pidx_d[k] = pidx_q[k-1];
    end

    case (state_q)
      IDLE: begin
        if (Start) begin
          if (cnt_clamp == 5'd0) begin
            done_d = 1'b1;
          end else begin
            state_d   = ISSUE;
            op_d      = Op;
            stride_d  = Stride;
            addr_d    = BaseAddr;
            last_d    = IDX_W'(cnt_clamp - 5'd1);
            iss_idx_d = '0;
          end
        end
      end
      ISSUE: begin
        // Address advances only when another element follows, so Addr holds after the last.
        if (iss_idx_q == last_q) begin
          state_d = op_q ? IDLE : DRAIN;
          done_d  = op_q;
        end else begin
          iss_idx_d = iss_idx_q + IDX_W'(1);
          addr_d    = addr_q + stride_q;
        end
      end
      DRAIN: begin
        if (vld_q[TAIL] && (pidx_q[TAIL] == last_q)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk1) begin
    if (Reset) begin
      state_q   <= IDLE;
      op_q      <= 1'b0;
      stride_q  <= '0;
      addr_q    <= '0;
      dout_q    <= '0;
      last_q    <= '0;
      iss_idx_q <= '0;
      done_q    <= 1'b0;
      vld_q     <= '0;
      pidx_q    <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      stride_q  <= stride_d;
      addr_q    <= addr_d;
      dout_q    <= dout_d;
      last_q    <= last_d;
      iss_idx_q <= iss_idx_d;
      done_q    <= done_d;
      vld_q     <= vld_d;
      pidx_q    <= pidx_d;
    end
  end

endmodule

// File: tb/tb_vec_mem_seq.sv
// Bench for vec_mem_seq: strided loads/stores checked cycle by cycle against offsets
// computed from the command, with a shadow copy of DRAM as the data reference.
module tb_vec_mem_seq;
  localparam int VLEN   = 16;
  localparam int RD_LAT = 1;
  localparam int KMAX   = 24;
  localparam int NCMD   = 40;

  logic        Clk1 = 1'b0;
  logic        Reset, Start, Op;
  logic [15:0] BaseAddr, Stride, ElemIn, ElemOut, Addr, DataOut, DataIn;
  logic [4:0]  Count;
  logic [3:0]  ElemIdx;
  logic        ElemWE, Busy, Done, RD, WR;

  logic [15:0] dram    [65536];
  logic [15:0] ref_mem [65536];
  logic [15:0] rf      [VLEN];
  logic [RD_LAT-1:0][15:0] rd_pipe;
  logic        init_mem;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [15:0] last_addr, last_dout;

  logic        o_rd [KMAX+1];
  logic        o_wr [KMAX+1];
  logic        o_we [KMAX+1];
  logic        o_busy [KMAX+1];
  logic        o_done [KMAX+1];
  logic [15:0] o_addr [KMAX+1];
  logic [15:0] o_dout [KMAX+1];
  logic [15:0] o_eout [KMAX+1];
  logic [3:0]  o_idx [KMAX+1];

  vec_mem_seq #(.VLEN(VLEN), .RD_LAT(RD_LAT)) dut (
    .Clk1(Clk1), .Reset(Reset), .Start(Start), .Op(Op), .BaseAddr(BaseAddr),
    .Stride(Stride), .Count(Count), .ElemIn(ElemIn), .ElemIdx(ElemIdx),
    .ElemOut(ElemOut), .ElemWE(ElemWE), .Busy(Busy), .Done(Done), .Addr(Addr),
    .RD(RD), .WR(WR), .DataOut(DataOut), .DataIn(DataIn)
  );

  always #5 Clk1 = ~Clk1;

  assign ElemIn = rf[ElemIdx];
  assign DataIn = rd_pipe[RD_LAT-1];

  function automatic logic [15:0] seed_word(input int a);
    return 16'((a * 40503) ^ 32'h5A5A);
  endfunction

  // DRAM model: synchronous write, reads return RD_LAT cycles after the strobe.
  always @(posedge Clk1) begin
    if (init_mem) begin
      for (int a = 0; a < 65536; a++) dram[a] <= seed_word(a);
    end else if (WR) begin
      dram[Addr] <= DataOut;
    end
    rd_pipe[0] <= RD ? dram[Addr] : 16'hDEAD;
    for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end

  function automatic int clampn(input logic [4:0] c);
    return (int'(c) > VLEN) ? VLEN : int'(c);
  endfunction

  function automatic int done_off(input logic op, input int n);
    if (n == 0) return 1;
    return op ? n + 1 : n + RD_LAT + 1;
  endfunction

  // Drives one command and records outputs for KMAX cycles after acceptance.
  task automatic run_cmd(input logic op, input logic [15:0] base, input logic [15:0] stride,
                         input logic [4:0] cnt, input int inject_k);
    @(negedge Clk1);
    Start = 1'b1; Op = op; BaseAddr = base; Stride = stride; Count = cnt;
    for (int k = 1; k <= KMAX; k++) begin
      @(negedge Clk1);
      o_rd[k] = RD; o_wr[k] = WR; o_we[k] = ElemWE; o_busy[k] = Busy; o_done[k] = Done;
      o_addr[k] = Addr; o_dout[k] = DataOut; o_eout[k] = ElemOut; o_idx[k] = ElemIdx;
      Start = (k == inject_k);
      if (k == inject_k) begin
        Op = ~op; BaseAddr = base ^ 16'h8000; Stride = 16'h0100; Count = 5'd3;
      end
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; Start = 1'b0; Op = 1'b0; BaseAddr = '0; Stride = '0; Count = '0;
    init_mem = 1'b1;
    for (int i = 0; i < VLEN; i++) rf[i] = '0;
    for (int a = 0; a < 65536; a++) ref_mem[a] = seed_word(a);
    @(negedge Clk1);
    @(negedge Clk1);
    init_mem = 1'b0;
    n_cmp++; if (Addr !== 16'h0)    begin n_fail++; $display("FAIL reset_addr got=%h exp=0000", Addr); end
    n_cmp++; if (RD !== 1'b0)       begin n_fail++; $display("FAIL reset_rd got=%b exp=0", RD); end
    n_cmp++; if (WR !== 1'b0)       begin n_fail++; $display("FAIL reset_wr got=%b exp=0", WR); end
    n_cmp++; if (DataOut !== 16'h0) begin n_fail++; $display("FAIL reset_dout got=%h exp=0000", DataOut); end
    n_cmp++; if (ElemIdx !== 4'h0)  begin n_fail++; $display("FAIL reset_idx got=%h exp=0", ElemIdx); end
    n_cmp++; if (ElemWE !== 1'b0)   begin n_fail++; $display("FAIL reset_we got=%b exp=0", ElemWE); end
    n_cmp++; if (Busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy got=%b exp=0", Busy); end
    n_cmp++; if (Done !== 1'b0)     begin n_fail++; $display("FAIL reset_done got=%b exp=0", Done); end
    Reset = 1'b0;
    last_addr = 16'h0;
    last_dout = 16'h0;
  endtask

  task automatic test_commands();
    logic        op, e_rd, e_wr, e_we;
    logic [15:0] base, stride, e_addr, e_dout, a;
    logic [4:0]  cnt;
    int          n, dk, j;
    for (int c = 0; c < NCMD; c++) begin
      case (c)
        0: begin op = 1'b0; base = 16'h0100; stride = 16'h0001; cnt = 5'd4;  end
        1: begin op = 1'b1; base = 16'h0200; stride = 16'h0002; cnt = 5'd3;  end
        2: begin op = 1'b0; base = 16'hFFFE; stride = 16'h0001; cnt = 5'd4;  end
        3: begin op = 1'b0; base = 16'h0003; stride = 16'hFFFF; cnt = 5'd4;  end
        4: begin op = 1'b1; base = 16'h0000; stride = 16'h0001; cnt = 5'd0;  end
        5: begin op = 1'b0; base = 16'h1234; stride = 16'h0003; cnt = 5'd20; end
        6: begin op = 1'b1; base = 16'hFFF0; stride = 16'h0005; cnt = 5'd20; end
        7: begin op = 1'b0; base = 16'h0200; stride = 16'h0002; cnt = 5'd3;  end
        default: begin
          op = 1'($urandom);
          base = 16'($urandom);
          stride = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 4));
          cnt = 5'($urandom_range(0, 20));
        end
      endcase
      for (int i = 0; i < VLEN; i++) rf[i] = (c == 1) ? 16'(16'h1111 * (i + 1)) : 16'($urandom);
      run_cmd(op, base, stride, cnt, 0);
      n  = clampn(cnt);
      dk = done_off(op, n);
      for (int k = 1; k <= KMAX; k++) begin
        j      = (k < n) ? k : n;
        e_rd   = !op && (k <= n);
        e_wr   = op && (k <= n);
        e_we   = !op && (k > RD_LAT) && (k <= n + RD_LAT);
        e_addr = (n == 0) ? last_addr : 16'(base + stride * (j - 1));
        e_dout = (op && n > 0) ? rf[j-1] : last_dout;
        n_cmp++; if (o_rd[k] !== e_rd)   begin n_fail++; $display("FAIL cmd_rd c=%0d k=%0d got=%b exp=%b", c, k, o_rd[k], e_rd); end
        n_cmp++; if (o_wr[k] !== e_wr)   begin n_fail++; $display("FAIL cmd_wr c=%0d k=%0d got=%b exp=%b", c, k, o_wr[k], e_wr); end
        n_cmp++; if (o_we[k] !== e_we)   begin n_fail++; $display("FAIL cmd_we c=%0d k=%0d got=%b exp=%b", c, k, o_we[k], e_we); end
        n_cmp++; if (o_addr[k] !== e_addr) begin n_fail++; $display("FAIL cmd_addr c=%0d k=%0d got=%h exp=%h", c, k, o_addr[k], e_addr); end
        n_cmp++; if (o_dout[k] !== e_dout) begin n_fail++; $display("FAIL cmd_dout c=%0d k=%0d got=%h exp=%h", c, k, o_dout[k], e_dout); end
        n_cmp++; if (o_busy[k] !== (n > 0 && k < dk)) begin n_fail++; $display("FAIL cmd_busy c=%0d k=%0d got=%b", c, k, o_busy[k]); end
        n_cmp++; if (o_done[k] !== (k == dk)) begin n_fail++; $display("FAIL cmd_done c=%0d k=%0d got=%b exp_cycle=%0d", c, k, o_done[k], dk); end
        if (e_wr) begin
          n_cmp++; if (o_idx[k] !== 4'(k - 1)) begin n_fail++; $display("FAIL cmd_st_idx c=%0d k=%0d got=%0d exp=%0d", c, k, o_idx[k], k - 1); end
        end
        if (e_we) begin
          a = 16'(base + stride * (k - 1 - RD_LAT));
          n_cmp++; if (o_idx[k] !== 4'(k - 1 - RD_LAT)) begin n_fail++; $display("FAIL cmd_ld_idx c=%0d k=%0d got=%0d exp=%0d", c, k, o_idx[k], k - 1 - RD_LAT); end
          n_cmp++; if (o_eout[k] !== ref_mem[a]) begin n_fail++; $display("FAIL cmd_ld_data c=%0d k=%0d got=%h exp=%h", c, k, o_eout[k], ref_mem[a]); end
        end
      end
      if (n > 0) begin
        last_addr = 16'(base + stride * (n - 1));
        if (op) last_dout = rf[n-1];
      end
      if (op) begin
        for (int i = 0; i < n; i++) ref_mem[16'(base + stride * i)] = rf[i];
        for (int i = 0; i < n; i++) begin
          a = 16'(base + stride * i);
          n_cmp++; if (dram[a] !== ref_mem[a]) begin n_fail++; $display("FAIL cmd_mem c=%0d addr=%h got=%h exp=%h", c, a, dram[a], ref_mem[a]); end
        end
      end
    end
  endtask

  task automatic test_busy_start();
    logic [15:0] base;
    int          dk;
    base = 16'($urandom);
    run_cmd(1'b0, base, 16'h0001, 5'd6, 2);
    dk = done_off(1'b0, 6);
    for (int k = 1; k <= KMAX; k++) begin
      n_cmp++; if (o_rd[k] !== (k <= 6)) begin n_fail++; $display("FAIL busy_rd k=%0d got=%b exp=%b", k, o_rd[k], (k <= 6)); end
      n_cmp++; if (o_wr[k] !== 1'b0)     begin n_fail++; $display("FAIL busy_wr k=%0d got=%b exp=0", k, o_wr[k]); end
      n_cmp++; if (o_done[k] !== (k == dk)) begin n_fail++; $display("FAIL busy_done k=%0d got=%b exp_cycle=%0d", k, o_done[k], dk); end
      if (k <= 6) begin
        n_cmp++; if (o_addr[k] !== 16'(base + k - 1)) begin n_fail++; $display("FAIL busy_addr k=%0d got=%h exp=%h", k, o_addr[k], 16'(base + k - 1)); end
      end
    end
    last_addr = 16'(base + 5);
  endtask

  task automatic test_back_to_back();
    logic        e_rd, e_wr, e_we;
    logic [15:0] a;
    for (int i = 0; i < VLEN; i++) rf[i] = 16'(16'hA000 + i);
    for (int i = 0; i < 3; i++) ref_mem[16'h0300 + 2 * i] = rf[i];
    @(negedge Clk1);
    Start = 1'b1; Op = 1'b1; BaseAddr = 16'h0300; Stride = 16'h0002; Count = 5'd3;
    for (int k = 1; k <= 14; k++) begin
      @(negedge Clk1);
      e_wr = (k <= 3);
      e_rd = (k >= 5) && (k <= 7);
      e_we = (k >= 5 + RD_LAT) && (k <= 7 + RD_LAT);
      n_cmp++; if (WR !== e_wr)   begin n_fail++; $display("FAIL b2b_wr k=%0d got=%b exp=%b", k, WR, e_wr); end
      n_cmp++; if (RD !== e_rd)   begin n_fail++; $display("FAIL b2b_rd k=%0d got=%b exp=%b", k, RD, e_rd); end
      n_cmp++; if (ElemWE !== e_we) begin n_fail++; $display("FAIL b2b_we k=%0d got=%b exp=%b", k, ElemWE, e_we); end
      n_cmp++; if (Done !== (k == 4 || k == 8 + RD_LAT)) begin n_fail++; $display("FAIL b2b_done k=%0d got=%b", k, Done); end
      if (e_wr || e_rd) begin
        a = 16'(16'h0300 + 2 * (e_wr ? k - 1 : k - 5));
        n_cmp++; if (Addr !== a) begin n_fail++; $display("FAIL b2b_addr k=%0d got=%h exp=%h", k, Addr, a); end
      end
      if (e_we) begin
        a = 16'(16'h0300 + 2 * (k - 5 - RD_LAT));
        n_cmp++; if (ElemOut !== ref_mem[a]) begin n_fail++; $display("FAIL b2b_data k=%0d got=%h exp=%h", k, ElemOut, ref_mem[a]); end
      end
      Start = 1'b0;
      if (k == 4) begin
        n_cmp++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_at_done got=%b exp=0", Busy); end
        Start = 1'b1; Op = 1'b0; BaseAddr = 16'h0300; Stride = 16'h0002; Count = 5'd3;
      end
    end
    last_addr = 16'h0304;
    last_dout = rf[2];
  endtask

  task automatic test_reset_abort();
    logic [15:0] base, stride, a;
    logic        e_we;
    int          dk;
    @(negedge Clk1);
    Start = 1'b1; Op = 1'b0; BaseAddr = 16'($urandom); Stride = 16'($urandom_range(1, 7)); Count = 5'd8;
    for (int k = 1; k <= 3; k++) begin
      @(negedge Clk1);
      Start = 1'b0;
    end
    Reset = 1'b1;
    @(negedge Clk1);
    Reset = 1'b0;
    n_cmp++; if (RD !== 1'b0)     begin n_fail++; $display("FAIL abort_rd got=%b exp=0", RD); end
    n_cmp++; if (WR !== 1'b0)     begin n_fail++; $display("FAIL abort_wr got=%b exp=0", WR); end
    n_cmp++; if (Busy !== 1'b0)   begin n_fail++; $display("FAIL abort_busy got=%b exp=0", Busy); end
    n_cmp++; if (ElemWE !== 1'b0) begin n_fail++; $display("FAIL abort_we got=%b exp=0", ElemWE); end
    n_cmp++; if (Addr !== 16'h0)  begin n_fail++; $display("FAIL abort_addr got=%h exp=0000", Addr); end
    for (int k = 5; k <= 16; k++) begin
      @(negedge Clk1);
      n_cmp++; if ({Done, ElemWE, RD, WR} !== 4'b0) begin n_fail++; $display("FAIL abort_quiet k=%0d done_we_rd_wr=%b exp=0000", k, {Done, ElemWE, RD, WR}); end
    end
    last_addr = 16'h0;
    last_dout = 16'h0;
    base   = 16'($urandom);
    stride = 16'($urandom);
    run_cmd(1'b0, base, stride, 5'd5, 0);
    dk = done_off(1'b0, 5);
    for (int k = 1; k <= KMAX; k++) begin
      e_we = (k > RD_LAT) && (k <= 5 + RD_LAT);
      n_cmp++; if (o_we[k] !== e_we) begin n_fail++; $display("FAIL post_abort_we k=%0d got=%b exp=%b", k, o_we[k], e_we); end
      n_cmp++; if (o_done[k] !== (k == dk)) begin n_fail++; $display("FAIL post_abort_done k=%0d got=%b exp_cycle=%0d", k, o_done[k], dk); end
      if (e_we) begin
        a = 16'(base + stride * (k - 1 - RD_LAT));
        n_cmp++; if (o_eout[k] !== ref_mem[a]) begin n_fail++; $display("FAIL post_abort_data k=%0d got=%h exp=%h", k, o_eout[k], ref_mem[a]); end
      end
    end
    last_addr = 16'(base + stride * 4);
  endtask

  initial begin
    test_reset();
    test_commands();
    test_busy_start();
    test_back_to_back();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/vec_mem_seq.md
Name: vec_mem_seq

Overview:
- Vector memory sequencer between the CVP14 core's vector load/store path and the DRAM model.
- Takes one vector load or store command: base address, stride and element count.
- Issues one DRAM access per cycle on the Addr/RD/WR/DataOut/DataIn bus.
- Loads: streams returned words into the vector register file write port. Stores: pulls words from the register file read port.

Parameters:
VLEN, 16, maximum elements per vector; ElemIdx width is log2(VLEN).
RD_LAT, 1, cycles from RD asserted with Addr to valid DataIn (1..4).

Ports:
Clk1  in  1  clock; all state updates on rising edge.
Reset  in  1  synchronous, active-high reset.
Start  in  1  command valid; accepted only when Busy=0.
Op  in  1  0=load, 1=store; sampled with Start.
BaseAddr  in  16  element 0 word address; sampled with Start.
Stride  in  16  address increment per element, mod 2^16; sampled with Start.
Count  in  5  element count; values >VLEN clamp to VLEN; 0 means no access.
ElemIn  in  16  store data from the register file for ElemIdx; combinational.
ElemIdx  out  4  element index: store = issue index, load = writeback index.
ElemOut  out  16  load data to the register file; equals DataIn.
ElemWE  out  1  register-file write enable for ElemOut at ElemIdx.
Busy  out  1  command in progress.
Done  out  1  one-cycle completion pulse.
Addr  out  16  DRAM address.
RD  out  1  DRAM read strobe.
WR  out  1  DRAM write strobe.
DataOut  out  16  DRAM write data.
DataIn  in  16  DRAM read data.

Behaviour:
- Reset: state IDLE, counters cleared, in-flight pipeline flushed. Outputs: Addr=0, RD=0, WR=0, DataOut=0, ElemIdx=0, ElemWE=0, Busy=0, Done=0.
- Reset mid-command aborts it. No ElemWE and no Done for aborted elements. RD and WR are 0 in the cycle after Reset is sampled.
- States: IDLE, ISSUE, DRAIN.
- IDLE:
  - Start=1 with clamped Count>0 latches Op, BaseAddr, Stride and Count, then goes to ISSUE.
  - Start=1 with Count=0 pulses Done next cycle and stays IDLE. No RD, WR or ElemWE.
- ISSUE: element i issues in cycle t+1+i, where t is the Start-accept cycle.
  - Addr = BaseAddr + i*Stride, truncated to 16 bits. Produced by an accumulator; wrap past 0xFFFF is legal.
  - Load: RD=1, WR=0.
  - Store: WR=1, RD=0, ElemIdx=i, DataOut=ElemIn in the same cycle.
  - After the last element: store returns to IDLE; load goes to DRAIN.
- DRAIN (load only): waits for outstanding reads. RD=0.
- Load writeback: element i produces ElemWE=1, ElemIdx=i, ElemOut=DataIn in cycle t+1+i+RD_LAT.
  - Track with a RD_LAT-deep valid/index shift register.
  - Writebacks overlap later issues: throughput is one element per cycle.
- Done:
  - Load: pulses in the cycle after the last ElemWE.
  - Store: pulses in the cycle after the last WR.
  - The FSM is in IDLE that cycle, so Busy=0 and a new Start is accepted in the same cycle.
- Busy=1 exactly in ISSUE and DRAIN.
- Start while Busy=1 is ignored: not queued, no effect.
- RD and WR are never both 1. When RD=0 and WR=0, Addr and DataOut hold their last values.
- Command latency:
  - Load: Count+RD_LAT+1 cycles from accept to Done.
  - Store: Count+1 cycles from accept to Done.

Test Plan:
- Load, Base=0x0100, Stride=1, Count=4, RD_LAT=1, mem[0x100..0x103]=A,B,C,D -> RD at t+1..t+4 with Addr 0x100..0x103; ElemWE at t+2..t+5 with idx 0..3 and data A..D; Done at t+6.
- Store, Base=0x0200, Stride=2, Count=3, ElemIn=0x1111*(idx+1) -> WR at t+1..t+3 with Addr 0x200, 0x202, 0x204 and DataOut 0x1111, 0x2222, 0x3333; Done at t+4; dumped memory matches.
- Wrap: load Base=0xFFFE, Stride=1, Count=4 -> Addr 0xFFFE, 0xFFFF, 0x0000, 0x0001; Stride=0xFFFF walks down by 1.
- Count=0 -> Done at t+1, no RD/WR/ElemWE. Count=20 -> exactly 16 accesses, idx 0..15.
- Start pulsed at t+2 during a busy load -> ignored, no address change; Start in the Done cycle -> accepted and the new command issues the next cycle.
- Reset asserted at t+3 of a Count=8 load -> RD=0, Busy=0 and ElemWE=0 from the next cycle; no Done; a subsequent load completes correctly.
